rto_core: RTL and testbench
===========================

// Module: rto_core
// PURPOSE
//  Real-time output core, the output-side counterpart of the timestamping input core. The CPU
//  queues {64-bit timestamp, N_OUT-bit pattern} events over the 32-bit register bus.
//  Each event's pattern drives dout when the shared 64-bit system counter reaches its timestamp.
//  Sits beside the input core on the same bus and counter; shares its cs/read/write/addr conventions.
// PARAMETERS
//  N_OUT    4   width of dout / event pattern (1..32)
//  FIFO_AW  4   log2 of event FIFO depth (depth = 16; 1..15)
// PORTS
//  clk      in   1      system clock (same domain as counter)
//  reset    in   1      asynchronous, active-high reset
//  cs       in   1      chip select; bus access only when high
//  read     in   1      read strobe (qualified by cs)
//  write    in   1      write strobe (qualified by cs)
//  addr     in   5      register address
//  wr_data  in   32     write data
//  rd_data  out  32     read data, registered
//  counter  in   64     free-running system timestamp counter
//  dout     out  N_OUT  registered output pattern
// BEHAVIOUR
//  Reset (async): dout=0, rd_data=0, FIFO empty, enable=0, sticky flags=0, staging regs=0.
//  Register map (write: cs&write; read: cs&read; a write takes effect at that clk edge):
//   0 TS_LO  W: staged timestamp[31:0]     1 TS_HI  W: staged timestamp[63:32]
//   2 DATA   W: push {staged ts, wr_data[N_OUT-1:0]} into FIFO; staging regs keep their values
//   3 STATUS R: [15:0] level, [16] empty, [17] full, [18] overflow, [19] late, [20] enable
//   4 CTRL   W: [0] enable, [1] flush (self-clearing), [2] clear overflow+late
//   5 DOUT   R: current dout, zero-extended
//   Other addresses: writes ignored, reads return 0. Read latency is 1 cycle; rd_data holds its
//   value until the next read.
//  Issue logic, evaluated every clk edge while enable=1 and FIFO non-empty:
//   - head.ts == counter: dout <= head.data and head is popped at that edge. dout is visible
//     1 cycle after counter==ts; software compensates.
//   - head.ts < counter (late): issued the same way, and late sticky is set.
//   - head.ts > counter: hold.
//   - At most one event issues per cycle. Equal timestamps issue on consecutive cycles; every
//     event after the first is then late.
//  Full: a push while full and with no pop that cycle is dropped and sets overflow sticky.
//   A push and a pop in the same cycle while full: the push is accepted and level is unchanged.
//  Empty: nothing issues and dout holds its value. Level counts 0..2^FIFO_AW and never wraps.
//  Pointers wrap modulo 2^FIFO_AW.
//  enable=0: the FIFO keeps filling, nothing issues, dout holds.
//  Flush: FIFO emptied at that edge; any same-cycle push or pop is discarded; dout holds.
//  Writing CTRL with both flush and clear: both actions occur. A late event in the same cycle as
//   a clear leaves late=1 (set wins).
//  Timestamp compare is unsigned 64-bit; counter wrap is not handled.
//  Async reset mid-operation clears everything immediately; no pending event survives.
// CONFIGURATION
//  RTO_CORE_LATE_DROP_EN defined: a late head (ts < counter) is popped WITHOUT driving dout,
//   and late sticky is still set. An on-time head (ts == counter) issues normally.
//  Undefined (default): late events are issued as described in BEHAVIOUR.
// TESTING
//  1 Reset pulse mid-stream with 3 events queued -> dout=0, STATUS=0x0001_0000, enable=0 after.
//  2 counter=100, enable=1; push ts=110 data=0xA -> at the edge where counter=110, dout=0xA on
//    the following cycle; STATUS.empty=1.
//  3 Push ts=50,51,51 data=1,2,3 while counter=40 -> dout=1 at 51, dout=2 at 52, dout=3 at 53;
//    late=1.
//  4 enable=0; push 17 events -> level=16, full=1, overflow=1; after CTRL clear, overflow=0.
//    Push while full concurrent with a pop (enable=1, due head) -> level stays 16.
//  5 counter=1000, push ts=900 data=0x5 -> default: dout=0x5 and late=1;
//    with RTO_CORE_LATE_DROP_EN: dout unchanged, late=1, FIFO empty.
//  6 Queue 4 events, write CTRL=0x3 -> level=0, dout unchanged; read addr 7 -> rd_data=0.

Source files
------------

// File: rtl/rto_core.sv
// rto_core: real-time output core. The CPU queues {64-bit timestamp, pattern}
// events over the register bus. Each event's pattern drives dout at the edge
// where the shared system counter reaches (or has passed) its timestamp.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   cs/read/write     bus strobes (read/write qualified by cs)
//   addr, wr_data     register address and write data
//   rd_data           registered read data; holds its value until the next read
//   counter           free-running 64-bit system timestamp counter
//   dout              registered output pattern
//
// Register map: 0 TS_LO(W) 1 TS_HI(W) 2 DATA(W, push) 3 STATUS(R) 4 CTRL(W) 5 DOUT(R)
// Build option: define RTO_CORE_LATE_DROP_EN to discard late events instead of
// driving them (the late flag is still set).
module rto_core #(
  parameter int N_OUT   = 4,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              read,
  input  logic              write,
  input  logic [4:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  input  logic [63:0]       counter,
  output logic [N_OUT-1:0]  dout
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef struct packed {
    logic [63:0]      ts;
    logic [N_OUT-1:0] data;
  } evt_t;

  evt_t               mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic [63:0]        stage_ts;
  logic               enable, overflow, late;

  logic   wr_en, rd_en, push_req, ctrl_wr, flush, clr;
  logic   empty, full, due, pop, push_ok, late_evt, drive;
  evt_t   head;
  logic [31:0] rd_mux;

  assign wr_en    = cs & write;
  assign rd_en    = cs & read;
  assign push_req = wr_en && (addr == 5'd2);
  assign ctrl_wr  = wr_en && (addr == 5'd4);
  assign flush    = ctrl_wr && wr_data[1];
  assign clr      = ctrl_wr && wr_data[2];

  assign empty = (level == '0);
  assign full  = (level == (FIFO_AW+1)'(DEPTH));
  assign head  = mem[rd_ptr];

  // Head issues once its timestamp is reached or already passed; a flush
  // in the same cycle wins over both the pop and any push.
  assign due      = enable && !empty && (head.ts <= counter);
  assign pop      = due && !flush;
  assign late_evt = pop && (head.ts < counter);
  // When full, a concurrent pop frees the slot the push lands in.
  assign push_ok  = push_req && !flush && (!full || pop);

`ifdef RTO_CORE_LATE_DROP_EN
  assign drive = pop && (head.ts == counter);
`else
  assign drive = pop;
`endif

  // Event storage needs no reset: level/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{ts: stage_ts, data: wr_data[N_OUT-1:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      stage_ts <= '0;
      enable   <= 1'b0;
      overflow <= 1'b0;
      late     <= 1'b0;
      dout     <= '0;
    end else begin
      if (wr_en && addr == 5'd0) stage_ts[31:0]  <= wr_data;
      if (wr_en && addr == 5'd1) stage_ts[63:32] <= wr_data;
      if (ctrl_wr) enable <= wr_data[0];

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !pop)      level <= level + 1'b1;
        else if (pop && !push_ok) level <= level - 1'b1;
      end

      if (drive) dout <= head.data;

      // Set has priority over clear for both sticky flags.
      if (push_req && !flush && full && !pop) overflow <= 1'b1;
      else if (clr)                           overflow <= 1'b0;
      if (late_evt) late <= 1'b1;
      else if (clr) late <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      5'd3: begin
        rd_mux[FIFO_AW:0] = level;
        rd_mux[16]        = empty;
        rd_mux[17]        = full;
        rd_mux[18]        = overflow;
        rd_mux[19]        = late;
        rd_mux[20]        = enable;
      end
      5'd5:    rd_mux[N_OUT-1:0] = dout;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_rto_core.sv
module tb_rto_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [63:0] counter;
  logic [3:0]  dout;

  int checks = 0;
  int errors = 0;
  logic [31:0] rv;
  logic [3:0]  exp_dout;

  rto_core #(.N_OUT(4), .FIFO_AW(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .counter(counter), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; read = 1'b0;
    d = rd_data;
  endtask

  task automatic tick_at(input logic [63:0] c);
    @(negedge clk);
    counter = c;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; cs = 0; read = 0; write = 0; addr = '0; wr_data = '0; counter = '0;
    #12;
    check("reset_dout", dout, 0);
    check("reset_rd_data", rd_data, 0);
    @(negedge clk); reset = 1'b0;
    bus_rd(5'd3, rv); check("reset_status", rv, 32'h0001_0000);

    // On-time issue: dout follows one edge after counter reaches ts.
    counter = 64'd100;
    bus_wr(5'd4, 32'h1);
    bus_wr(5'd0, 32'd110);
    bus_wr(5'd2, 32'hA);
    tick_at(64'd109); check("t2_hold", dout, 4'h0);
    tick_at(64'd110); check("t2_issue", dout, 4'hA);
    bus_rd(5'd3, rv); check("t2_status", rv, 32'h0011_0000);

    // Equal timestamps issue on consecutive cycles; the third is late.
    tick_at(64'd40);
    bus_wr(5'd0, 32'd50); bus_wr(5'd2, 32'h1);
    bus_wr(5'd0, 32'd51); bus_wr(5'd2, 32'h2); bus_wr(5'd2, 32'h3);
    check("t3_hold", dout, 4'hA);
    tick_at(64'd50); check("t3_ev1", dout, 4'h1);
    tick_at(64'd51); check("t3_ev2", dout, 4'h2);
    tick_at(64'd52); check("t3_ev3", dout, 4'h3);
    bus_rd(5'd3, rv); check("t3_late", rv, 32'h0019_0000);
    bus_wr(5'd4, 32'h5);
    bus_rd(5'd3, rv); check("t3_clear", rv, 32'h0011_0000);

    // Fill past capacity with issue disabled; then push+pop while full.
    bus_wr(5'd4, 32'h0);
    counter = 64'd200;
    bus_wr(5'd0, 32'd300);
    for (int i = 0; i < 17; i++) bus_wr(5'd2, 32'((i + 1) & 15));
    bus_rd(5'd3, rv); check("t4_full_ovf", rv, 32'h0006_0010);
    bus_wr(5'd4, 32'h4);
    bus_rd(5'd3, rv); check("t4_clear_ovf", rv, 32'h0002_0010);
    counter = 64'd300;
    bus_wr(5'd4, 32'h1);
    check("t4_no_pop_yet", dout, 4'h3);
    bus_wr(5'd2, 32'h7);
    counter = 64'd250;
    check("t4_pop_dout", dout, 4'h1);
    bus_rd(5'd3, rv); check("t4_pushpop_level", rv, 32'h0012_0010);
    bus_wr(5'd4, 32'h2);
    bus_rd(5'd3, rv); check("t4_flush", rv, 32'h0001_0000);

    // Late event: issued by default, discarded with the drop option.
    counter = 64'd1000;
    bus_wr(5'd4, 32'h1);
    bus_wr(5'd0, 32'd900);
    bus_wr(5'd2, 32'h5);
    @(posedge clk); #1;
`ifdef RTO_CORE_LATE_DROP_EN
    exp_dout = 4'h1;
`else
    exp_dout = 4'h5;
`endif
    check("t5_late_dout", dout, exp_dout);
    bus_rd(5'd3, rv); check("t5_late_status", rv, 32'h0019_0000);
    bus_wr(5'd4, 32'h5);

    // Future timestamp in the high word must hold, not go late.
    bus_wr(5'd1, 32'h1);
    bus_wr(5'd2, 32'hE);
    tick_at(64'd1001); tick_at(64'd1002);
    check("t5_hi_hold", dout, exp_dout);
    bus_rd(5'd3, rv); check("t5_hi_status", rv, 32'h0010_0001);
    bus_wr(5'd1, 32'h0);

    // Flush with enable in one CTRL write; dout holds; unmapped read is 0.
    bus_wr(5'd4, 32'h0);
    for (int i = 0; i < 3; i++) bus_wr(5'd2, 32'h9);
    bus_rd(5'd3, rv); check("t6_level4", rv, 32'h0000_0004);
    bus_wr(5'd4, 32'h3);
    bus_rd(5'd3, rv); check("t6_flushed", rv, 32'h0011_0000);
    check("t6_dout_hold", dout, exp_dout);
    bus_rd(5'd5, rv); check("t6_dout_reg", rv, 32'(exp_dout));
    bus_wr(5'd0, 32'd1234);
    check("t6_rd_hold", rd_data, 32'(exp_dout));
    bus_rd(5'd7, rv); check("t6_unmapped", rv, 32'h0);

    // Asynchronous reset mid-stream with queued events.
    bus_wr(5'd4, 32'h0);
    for (int i = 0; i < 3; i++) bus_wr(5'd2, 32'h6);
    bus_rd(5'd3, rv); check("t1_queued", rv, 32'h0000_0003);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    check("t1_async_dout", dout, 0);
    check("t1_async_rd", rd_data, 0);
    @(negedge clk); reset = 1'b0;
    bus_rd(5'd3, rv); check("t1_status", rv, 32'h0001_0000);
    bus_wr(5'd4, 32'h1);
    tick_at(64'd5000); tick_at(64'd5001); tick_at(64'd5002);
    check("t1_no_survivor", dout, 0);
    bus_rd(5'd3, rv); check("t1_status_en", rv, 32'h0011_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
